// File: rtl/mont_mul_ctrl.sv
// rtl/mont_mul_ctrl.sv - radix-4 Montgomery multiplier sequencer
// Feeds an external carry-save datapath, then resolves and reduces the result in ADD_W chunks.
module mont_mul_ctrl #(
  parameter int ADD_W  = 128,
  parameter int N_BITS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [N_BITS-1:0] in_a,
  input  logic [N_BITS-1:0] in_b,
  input  logic [N_BITS-1:0] in_m,
  output logic              err_even_m,
  output logic              busy,
  output logic [N_BITS:0]   csa_in_C,
  output logic [N_BITS-1:0] csa_in_S,
  output logic              csa_carry_in,
  output logic [N_BITS-1:0] csa_m,
  output logic [N_BITS+1:0] csa_3m,
  output logic [N_BITS+1:0] csa_kb_a,
  output logic [N_BITS+1:0] csa_kb_b,
  input  logic [N_BITS:0]   csa_out_C,
  input  logic [N_BITS-1:0] csa_out_S,
  input  logic              csa_carry_out,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int NCH = N_BITS / ADD_W;
  localparam int BW  = $clog2(N_BITS);
  localparam logic [7:0] LOOP_LAST = 8'(N_BITS / 4 - 1);
  localparam logic [7:0] CH_LAST   = 8'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE0, S_PRE1, S_LOOP, S_ADD, S_SUB, S_DONE
  } state_t;

  state_t state, state_n;

  logic [N_BITS-1:0] a_sh;
  logic [N_BITS-1:0] b_reg;
  logic [N_BITS+1:0] b3_reg;
  logic [N_BITS+1:0] t_reg;
  logic [7:0]        cnt;
  logic              ch_c;

  function automatic logic [N_BITS+1:0] kb_sel(input logic [1:0] d,
                                               input logic [N_BITS-1:0] b,
                                               input logic [N_BITS+1:0] b3);
    case (d)
      2'd0:    kb_sel = '0;
      2'd1:    kb_sel = {2'b00, b};
      2'd2:    kb_sel = {1'b0, b, 1'b0};
      default: kb_sel = b3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    ready        = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start && in_m[0]) state_n = S_PRE0;
      end
      S_PRE0: state_n = S_PRE1;
      S_PRE1: state_n = S_LOOP;
      S_LOOP: if (cnt == LOOP_LAST) state_n = S_ADD;
      S_ADD:  if (cnt == CH_LAST) state_n = S_SUB;
      S_SUB:  if (cnt == CH_LAST) state_n = S_DONE;
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One tripling adder shared by 3M (PRE0) and 3B (PRE1).
  logic [N_BITS+1:0] pre_x, pre_sum, b3_now;
  logic [3:0]        dig;
  assign pre_x   = (state == S_PRE0) ? {2'b00, csa_m} : {2'b00, b_reg};
  assign pre_sum = pre_x + (pre_x << 1);
  assign b3_now  = (state == S_PRE1) ? pre_sum : b3_reg;
  // kb registers are loaded one cycle ahead, so LOOP looks at the next digit pair.
  assign dig     = (state == S_PRE1) ? a_sh[3:0] : a_sh[7:4];

  logic [BW-1:0]     base;
  logic              cin, bin;
  logic [ADD_W:0]    add_sum, sub_diff;
  logic [N_BITS-1:0] d_full;

  assign base = BW'(cnt) * BW'(ADD_W);
  assign cin  = (cnt == 8'd0) ? csa_carry_in : ch_c;
  assign bin  = (cnt == 8'd0) ? 1'b0 : ch_c;
  assign add_sum  = {1'b0, csa_in_S[base +: ADD_W]} + {1'b0, csa_in_C[base +: ADD_W]}
                  + {{ADD_W{1'b0}}, cin};
  assign sub_diff = {1'b0, t_reg[base +: ADD_W]} - {1'b0, csa_m[base +: ADD_W]}
                  - {{ADD_W{1'b0}}, bin};

  // A is exhausted after LOOP, so its register collects the difference chunks.
  always_comb begin
    d_full = a_sh;
    d_full[base +: ADD_W] = sub_diff[ADD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh         <= '0;
      b_reg        <= '0;
      b3_reg       <= '0;
      t_reg        <= '0;
      cnt          <= '0;
      ch_c         <= 1'b0;
      err_even_m   <= 1'b0;
      csa_in_C     <= '0;
      csa_in_S     <= '0;
      csa_carry_in <= 1'b0;
      csa_m        <= '0;
      csa_3m       <= '0;
      csa_kb_a     <= '0;
      csa_kb_b     <= '0;
      result       <= '0;
    end else begin
      err_even_m <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && in_m[0]) begin
            a_sh         <= in_a;
            b_reg        <= in_b;
            csa_m        <= in_m;
            csa_in_C     <= '0;
            csa_in_S     <= '0;
            csa_carry_in <= 1'b0;
            cnt          <= '0;
          end else if (start) begin
            err_even_m <= 1'b1;
          end
        end
        S_PRE0: csa_3m <= pre_sum;
        S_PRE1: begin
          b3_reg   <= pre_sum;
          csa_kb_a <= kb_sel(dig[1:0], b_reg, b3_now);
          csa_kb_b <= kb_sel(dig[3:2], b_reg, b3_now);
        end
        S_LOOP: begin
          csa_in_C     <= csa_out_C;
          csa_in_S     <= csa_out_S;
          csa_carry_in <= csa_carry_out;
          a_sh         <= a_sh >> 4;
          if (cnt == LOOP_LAST) begin
            cnt      <= '0;
            csa_kb_a <= '0;
            csa_kb_b <= '0;
          end else begin
            cnt      <= cnt + 8'd1;
            csa_kb_a <= kb_sel(dig[1:0], b_reg, b3_reg);
            csa_kb_b <= kb_sel(dig[3:2], b_reg, b3_reg);
          end
        end
        S_ADD: begin
          t_reg[base +: ADD_W] <= add_sum[ADD_W-1:0];
          ch_c <= add_sum[ADD_W];
          if (cnt == CH_LAST) begin
            t_reg[N_BITS+1:N_BITS] <= {1'b0, csa_in_C[N_BITS]} + {1'b0, add_sum[ADD_W]};
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SUB: begin
          a_sh <= d_full;
          ch_c <= sub_diff[ADD_W];
          if (cnt == CH_LAST) begin
            // T may reach 2^N_BITS, in which case the subtraction always applies.
            result <= (t_reg[N_BITS+1:N_BITS] != 2'b00 || !sub_diff[ADD_W]) ? d_full
                                                                            : t_reg[N_BITS-1:0];
            cnt    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// tb/tb_mont_mul_ctrl.sv - self-checking bench for mont_mul_ctrl
// Models the carry-save datapath arithmetically and checks results against a REDC-free reference.
module tb_mont_mul_ctrl;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic [1023:0] in_a = '0, in_b = '0, in_m = '0;
  logic          err_even_m, busy;
  logic [1024:0] csa_in_C;
  logic [1023:0] csa_in_S;
  logic          csa_carry_in;
  logic [1023:0] csa_m;
  logic [1025:0] csa_3m, csa_kb_a, csa_kb_b;
  logic [1024:0] csa_out_C = '0;
  logic [1023:0] csa_out_S = '0;
  logic          csa_carry_out = 1'b0;
  logic [1023:0] result;
  logic          result_valid;
  logic          result_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  mont_mul_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .err_even_m(err_even_m), .busy(busy),
    .csa_in_C(csa_in_C), .csa_in_S(csa_in_S), .csa_carry_in(csa_carry_in),
    .csa_m(csa_m), .csa_3m(csa_3m), .csa_kb_a(csa_kb_a), .csa_kb_b(csa_kb_b),
    .csa_out_C(csa_out_C), .csa_out_S(csa_out_S), .csa_carry_out(csa_carry_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Datapath: two radix-4 Montgomery steps on the represented value, re-split at random.
  logic [1029:0] dp_x, dp_c;
  logic [1:0]    dp_q;
  logic [1023:0] dp_rnd, dp_s;
  logic          dp_cy;
  always @(negedge clk) begin
    dp_x = 1030'(csa_in_C) + 1030'(csa_in_S) + 1030'(csa_carry_in);
    dp_x = dp_x + 1030'(csa_kb_a);
    dp_q = 2'd0 - 2'(dp_x[1:0] * csa_m[1:0]);
    dp_x = (dp_x + 1030'(dp_q) * 1030'(csa_m)) >> 2;
    dp_x = dp_x + 1030'(csa_kb_b);
    dp_q = 2'd0 - 2'(dp_x[1:0] * csa_m[1:0]);
    dp_x = (dp_x + 1030'(dp_q) * 1030'(csa_m)) >> 2;
    dp_cy = (dp_x != '0) ? 1'($urandom_range(0, 1)) : 1'b0;
    dp_x  = dp_x - 1030'(dp_cy);
    for (int i = 0; i < 32; i++) dp_rnd[32*i +: 32] = $urandom;
    dp_s = dp_x[1023:0] & dp_rnd;
    dp_c = dp_x - 1030'(dp_s);
    csa_out_S     = dp_s;
    csa_out_C     = dp_c[1024:0];
    csa_carry_out = dp_cy;
  end

  function automatic logic [1023:0] rand_w();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // A*B mod M, then divide by two 1024 times modulo M.
  function automatic logic [1023:0] ref_mont(input logic [1023:0] a, input logic [1023:0] b,
                                            input logic [1023:0] m);
    logic [2047:0] p;
    logic [1024:0] r;
    p = {1024'b0, a} * {1024'b0, b};
    p = p % {1024'b0, m};
    r = {1'b0, p[1023:0]};
    for (int i = 0; i < 1024; i++) begin
      if (r[0]) r = r + {1'b0, m};
      r = r >> 1;
    end
    return r[1023:0];
  endfunction

  task automatic chk(input string name, input logic [1025:0] act, input logic [1025:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
  endtask

  task automatic rand_ops(output logic [1023:0] a, output logic [1023:0] b,
                          output logic [1023:0] m);
    m = rand_w() >> $urandom_range(0, 8);
    m[0] = 1'b1;
    a = rand_w() % m;
    b = rand_w() % m;
  endtask

  // Called #1 after an edge with the DUT in IDLE; returns #1 after the accept edge.
  task automatic start_op(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_a = ~a; in_b = ~b; in_m = rand_w();
  endtask

  task automatic wait_valid(input bit poke, output int lat, output logic [1025:0] m3s);
    lat = 0;
    m3s = '0;
    while (!result_valid && lat < 400) begin
      start = poke && (lat == 40 || lat == 270);
      if (start) in_m = rand_w() | 1024'd1;
      @(posedge clk); #1;
      lat++;
      if (lat == 5) m3s = csa_3m;
    end
    start = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  typedef struct {
    logic [1023:0] a, b, m, exp;
  } vec_t;

  vec_t          tbl[5];
  logic [1023:0] a, b, m, exp_r, held;
  logic [1025:0] m3s;
  int            lat;
  bit            stable;

  initial begin
    tbl[0] = '{a: 1024'd1, b: 1024'd1, m: 1024'd3, exp: 1024'd1};
    tbl[1] = '{a: 1024'd1, b: 1024'h1234, m: {1024{1'b1}}, exp: 1024'h1234};
    tbl[2] = '{a: 1024'd1, b: {{1023{1'b1}}, 1'b0}, m: {1024{1'b1}}, exp: {{1023{1'b1}}, 1'b0}};
    rand_ops(a, b, m);
    tbl[3] = '{a: 1024'd0, b: b, m: m, exp: 1024'd0};
    tbl[4] = '{a: 1024'd2, b: 1024'd1, m: 1024'd3, exp: 1024'd2};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", 1026'(ready), 1026'd1);
    chk("rst_busy", 1026'(busy), 1026'd0);
    chk("rst_valid", 1026'(result_valid), 1026'd0);
    chk("rst_err", 1026'(err_even_m), 1026'd0);
    chk("rst_result", 1026'(result), 1026'd0);
    chk("rst_csa_c", 1026'(csa_in_C), 1026'd0);

    in_m = 1024'd4; in_a = 1024'd1; in_b = 1024'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("even_err_pulse", 1026'(err_even_m), 1026'd1);
    chk("even_ready", 1026'(ready), 1026'd1);
    chk("even_busy", 1026'(busy), 1026'd0);
    @(posedge clk); #1;
    chk("even_err_clear", 1026'(err_even_m), 1026'd0);
    chk("even_still_idle", 1026'(ready), 1026'd1);

    for (int i = 0; i < 5; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].m);
      chk($sformatf("tbl%0d_busy", i), 1026'(busy), 1026'd1);
      wait_valid(1'b0, lat, m3s);
      chk($sformatf("tbl%0d_lat", i), 1026'(lat), 1026'd274);
      chk($sformatf("tbl%0d_3m", i), m3s, 1026'(tbl[i].m) * 1026'd3);
      chk($sformatf("tbl%0d_res", i), 1026'(result), 1026'(tbl[i].exp));
      chk($sformatf("tbl%0d_kb_done", i), csa_kb_a | csa_kb_b, 1026'd0);
      accept();
    end

    rand_ops(a, b, m);
    exp_r = ref_mont(a, b, m);
    start_op(a, b, m);
    wait_valid(1'b1, lat, m3s);
    chk("poke_lat", 1026'(lat), 1026'd274);
    chk("poke_res", 1026'(result), 1026'(exp_r));
    held = result;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      @(posedge clk); #1;
      if (!result_valid || result !== held) stable = 1'b0;
    end
    start = 1'b0;
    chk("bp_stable", 1026'(stable), 1026'd1);
    accept();
    chk("bp_release_ready", 1026'(ready), 1026'd1);
    chk("bp_release_valid", 1026'(result_valid), 1026'd0);

    start_op(1024'd5, 1024'd7, 1024'd11);
    repeat (102) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 1026'(ready), 1026'd1);
    chk("midrst_busy", 1026'(busy), 1026'd0);
    chk("midrst_csa_c", 1026'(csa_in_C), 1026'd0);
    chk("midrst_kb", csa_kb_a | csa_kb_b | csa_3m, 1026'd0);
    chk("midrst_result", 1026'(result), 1026'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postrst_ready", 1026'(ready), 1026'd1);
    start_op(1024'd2, 1024'd1, 1024'd3);
    wait_valid(1'b0, lat, m3s);
    chk("postrst_lat", 1026'(lat), 1026'd274);
    chk("postrst_res", 1026'(result), 1026'd2);
    accept();

    for (int v = 0; v < 150; v++) begin
      rand_ops(a, b, m);
      exp_r = ref_mont(a, b, m);
      start_op(a, b, m);
      wait_valid(1'b0, lat, m3s);
      chk($sformatf("rnd%0d_lat", v), 1026'(lat), 1026'd274);
      chk($sformatf("rnd%0d_res", v), 1026'(result), 1026'(exp_r));
      accept();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
